// File: rtl/jtframe_68k_pkg.sv
// Shared definitions for the 68000 bus arbitration blocks.
// The state encoding is shared with the device-side requester so checkers can decode it.
package jtframe_68k_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_OWNED = 2'd3;

endpackage

// File: rtl/jtframe_sync2.sv
// Two-flop synchronizer for active-low control inputs. It resets to the inactive level (1)
// and runs on every clk, independent of cen.
module jtframe_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ff <= 2'b11;
        else     r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/jtframe_68kbusarb.sv
// CPU-side 68000 bus arbiter: samples BRn, grants at a bus-cycle boundary, stalls the
// core while a device owns the bus, and flags ownership that lasts too long.
module jtframe_68kbusarb
    import jtframe_68k_pkg::*;
#(
    parameter int SYNC  = 0,
    parameter int TOW   = 8,
    parameter int TOMAX = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic cpu_ASn,
    input  logic cpu_rmw,
    input  logic dev_BRn,
    input  logic dev_BGACKn,
    output logic dev_BGn,
    output logic cpu_hold,
    output logic owned,
    output logic timeout
);

    localparam logic [TOW-1:0] WD_MAX = TOW'(TOMAX);
    localparam logic [TOW-1:0] WD_PRE = TOW'(TOMAX - 1);
    localparam logic [TOW-1:0] WD_ONE = TOW'(1);

    logic           w_brn;
    logic           w_bgackn;
    logic           w_br;
    logic           w_ack;

    logic [1:0]     r_state;
    logic           r_bgn;
    logic           r_hold;
    logic           r_owned;
    logic           r_timeout;
    logic [TOW-1:0] r_wd;

    generate
        if (SYNC != 0) begin : g_sync
            jtframe_sync2 u_sync_br (
                .clk (clk),
                .rst (rst),
                .i_d (dev_BRn),
                .o_q (w_brn)
            );
            jtframe_sync2 u_sync_ack (
                .clk (clk),
                .rst (rst),
                .i_d (dev_BGACKn),
                .o_q (w_bgackn)
            );
        end else begin : g_nosync
            assign w_brn    = dev_BRn;
            assign w_bgackn = dev_BGACKn;
        end
    endgenerate

    assign w_br  = ~w_brn;
    assign w_ack = ~w_bgackn;

    // An acknowledge always wins over a dropped request, so a device that grabs the bus is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bgn     <= 1'b1;
            r_hold    <= 1'b0;
            r_owned   <= 1'b0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
        end else if (cen) begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ack) begin
                        r_state <= ST_OWNED;
                        r_bgn   <= 1'b1;
                        r_hold  <= 1'b1;
                        r_owned <= 1'b1;
                        r_wd    <= '0;
                    end else if (w_br) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!w_br) begin
                        r_state <= ST_IDLE;
                    end else if (cpu_ASn && !cpu_rmw) begin
                        r_state <= ST_GRANT;
                        r_bgn   <= 1'b0;
                        r_hold  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_ack) begin
                        r_state <= ST_OWNED;
                        r_bgn   <= 1'b1;
                        r_owned <= 1'b1;
                        r_wd    <= '0;
                    end else if (!w_br) begin
                        r_state <= ST_IDLE;
                        r_bgn   <= 1'b1;
                        r_hold  <= 1'b0;
                    end
                end
                ST_OWNED: begin
                    if (!w_ack) begin
                        r_state <= ST_IDLE;
                        r_hold  <= 1'b0;
                        r_owned <= 1'b0;
                    end else if (r_wd != WD_MAX) begin
                        r_wd      <= r_wd + WD_ONE;
                        r_timeout <= (r_wd == WD_PRE);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dev_BGn  = r_bgn;
    assign cpu_hold = r_hold;
    assign owned    = r_owned;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_jtframe_68kbusarb.sv
// Directed bench for jtframe_68kbusarb: one unsynchronized arbiter (TOMAX=5) plus a
// synchronized twin that is only checked for its extra two-clock latency.
module tb_jtframe_68kbusarb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    logic cpuASn = 1'b1;
    logic cpuRmw = 1'b0;
    logic devBRn = 1'b1;
    logic devBGACKn = 1'b1;

    logic bgn, hold, own, tmo;
    logic sBgn, sHold, sOwn, sTmo;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtframe_68kbusarb #(.SYNC(0), .TOW(8), .TOMAX(5)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .cpu_ASn    (cpuASn),
        .cpu_rmw    (cpuRmw),
        .dev_BRn    (devBRn),
        .dev_BGACKn (devBGACKn),
        .dev_BGn    (bgn),
        .cpu_hold   (hold),
        .owned      (own),
        .timeout    (tmo)
    );

    jtframe_68kbusarb #(.SYNC(1), .TOW(8), .TOMAX(5)) u_dutSync (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .cpu_ASn    (cpuASn),
        .cpu_rmw    (cpuRmw),
        .dev_BRn    (devBRn),
        .dev_BGACKn (devBGACKn),
        .dev_BGn    (sBgn),
        .cpu_hold   (sHold),
        .owned      (sOwn),
        .timeout    (sTmo)
    );

    task automatic applyStimulus(input logic brn, input logic bgackn, input logic asn,
                                 input logic rmw, input logic ce = 1'b1);
        devBRn    = brn;
        devBGACKn = bgackn;
        cpuASn    = asn;
        cpuRmw    = rmw;
        cen       = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eBgn, input logic eHold,
                               input logic eOwned, input logic eTmo);
        checkBit({tag, ".BGn"},     bgn,  eBgn);
        checkBit({tag, ".hold"},    hold, eHold);
        checkBit({tag, ".owned"},   own,  eOwned);
        checkBit({tag, ".timeout"}, tmo,  eTmo);
    endtask

    task automatic checkSync(input string tag, input logic eBgn, input logic eHold,
                             input logic eOwned);
        checkBit({tag, ".sBGn"},   sBgn,  eBgn);
        checkBit({tag, ".sHold"},  sHold, eHold);
        checkBit({tag, ".sOwned"}, sOwn,  eOwned);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        checkSync("reset", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] basic grant");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("basic.req", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("basic.grant", 1'b0, 1'b1, 1'b0, 1'b0);
        checkSync("basic.syncIdle", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkSync("basic.syncReq", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("basic.waitAck", 1'b0, 1'b1, 1'b0, 1'b0);
        checkSync("basic.syncGrant", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("basic.owned", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("basic.ownedHeld", 1'b1, 1'b1, 1'b1, 1'b0);
        checkSync("basic.syncOwned", 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("basic.release", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkSync("basic.syncStillOwned", 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkSync("basic.syncRelease", 1'b1, 1'b0, 1'b0);

        $display("[TB] bus-cycle boundary on ASn");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("asn.blocked", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("asn.grant", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("asn.ackWins", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("asn.release", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] bus-cycle boundary on rmw");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i <= 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("rmw.blocked", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rmw.grant", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rmw.rescindGrant", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] rescind before grant");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rescind.req", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("rescind.idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] simultaneous grant/ack and back-to-back request");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b2b.grantFirst", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b2b.owned", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b2b.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b2b.req", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b2b.regrant", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("b2b.release", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] watchdog");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("wd.entry", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("wd.tick%0d", i), 1'b1, 1'b1, 1'b1, (i == 5));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("wd.release", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] cen every third clock");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, (i % 3 == 0));
            checkOutput($sformatf("cen.clk%0d", i), (i < 3), (i >= 3), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, (i == 0));
            checkOutput($sformatf("cen.owned%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
        end

        $display("[TB] reset during ownership");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstOwned", 1'b1, 1'b0, 1'b0, 1'b0);
        checkSync("rstOwned", 1'b1, 1'b0, 1'b0);
        devBRn    = 1'b1;
        devBGACKn = 1'b1;
        cen       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("postReset", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
